// File: rtl/ib_cascade_pkg.sv
// Shared definitions for the 6-input information-bottleneck check-node cascade.
//   - FSM state encoding for the cascade sequencing controller
//   - Per-stage decomposed-LUT counts and base indices (f0..f3) for decoding lut_sel
//   - Derived LUT address width helper
package ib_cascade_pkg;

  // Controller FSM state encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] cascade_state_t;
  localparam cascade_state_t StIdle   = 2'd0;
  localparam cascade_state_t StDrain  = 2'd1;
  localparam cascade_state_t StLoad   = 2'd2;
  localparam cascade_state_t StFinish = 2'd3;

  localparam int unsigned NumStages = 4;

  // Decomposed 2-LUTs per stage and the first lut_sel index of each stage.
  localparam int unsigned StageLutNum  [NumStages] = '{2, 2, 4, 6};
  localparam int unsigned StageLutBase [NumStages] = '{0, 2, 4, 8};

  localparam int unsigned DefQuanSize = 4;
  localparam int unsigned LutAddrW    = 2 * DefQuanSize;

  // A 2-LUT is addressed by two messages side by side.
  function automatic int unsigned lut_addr_w(input int unsigned quan_size);
    return 2 * quan_size;
  endfunction

  // Stage (0..3 for f0..f3) that owns a given lut_sel index.
  function automatic int unsigned lut_stage(input int unsigned sel);
    int unsigned stage;
    stage = 0;
    for (int s = 0; s < NumStages; s++) begin
      if (sel >= StageLutBase[s]) stage = s;
    end
    return stage;
  endfunction

endpackage

// File: rtl/ib_cnu6_cascade_ctrl_if.sv
// Handshake and LUT-load bus of the cascade controller.
//   master : upstream v2c source and LUT loader (drives v2c_valid, load_req, lut_wdata_valid)
//   slave  : ib_cnu6_cascade_ctrl (drives ready, stage/c2v validity, LUT write strobes)
interface ib_cnu6_cascade_ctrl_if #(
  parameter int unsigned QUAN_SIZE = 4,
  parameter int unsigned LUT_NUM   = 14
);
  logic                       v2c_valid;
  logic                       v2c_ready;
  logic [3:0]                 stage_valid;
  logic                       c2v_valid;
  logic                       load_req;
  logic                       lut_wdata_valid;
  logic                       lut_we;
  logic [$clog2(LUT_NUM)-1:0] lut_sel;
  logic [2*QUAN_SIZE-1:0]     lut_addr;
  logic                       load_done;

  modport master (
    output v2c_valid, load_req, lut_wdata_valid,
    input  v2c_ready, stage_valid, c2v_valid, lut_we, lut_sel, lut_addr, load_done
  );

  modport slave (
    input  v2c_valid, load_req, lut_wdata_valid,
    output v2c_ready, stage_valid, c2v_valid, lut_we, lut_sel, lut_addr, load_done
  );

endinterface

// File: rtl/ib_lut_load_walker.sv
// Address walker for the LUT reload window.
//   read_clk, rstn : clock, synchronous active-low reset
//   clear          : hold the walk at lut_sel=0, lut_addr=0
//   advance        : one table word written this cycle; step to the next entry
//   lut_sel        : decomposed LUT currently being written
//   lut_addr       : entry within that LUT
//   last           : current position is the final entry of the final LUT
module ib_lut_load_walker #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LUT_NUM = 14,
  parameter int unsigned SEL_W   = $clog2(LUT_NUM)
) (
  input  logic              read_clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              advance,
  output logic [SEL_W-1:0]  lut_sel,
  output logic [ADDR_W-1:0] lut_addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] AddrMax = '1;
  localparam logic [SEL_W-1:0]  SelMax  = SEL_W'(LUT_NUM - 1);

  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_wrap;

  assign addr_wrap = (addr_q == AddrMax);
  assign last      = addr_wrap && (sel_q == SelMax);

  always_comb begin
    sel_d  = sel_q;
    addr_d = addr_q;
    if (clear) begin
      sel_d  = '0;
      addr_d = '0;
    end else if (advance) begin
      // Address rolls over to 0 on its own at the end of a table.
      addr_d = addr_q + ADDR_W'(1);
      if (addr_wrap) begin
        sel_d = last ? '0 : sel_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge read_clk) begin
    if (!rstn) begin
      sel_q  <= '0;
      addr_q <= '0;
    end else begin
      sel_q  <= sel_d;
      addr_q <= addr_d;
    end
  end

  assign lut_sel  = sel_q;
  assign lut_addr = addr_q;

endmodule

// File: rtl/ib_cnu6_cascade_ctrl.sv
// Sequencing controller for the 6-input IB check-node cascade (stages f0..f3).
// Admits v2c groups, tracks their validity through the four pipelined stages, and
// owns the exclusive LUT-reload window (drain, then walk every LUT entry).
//   read_clk, rstn : clock, synchronous active-low reset
//   bus (slave)    : v2c handshake, stage/c2v validity, LUT load request and write port
//   busy           : FSM not idle, or a group still in the pipeline
//   done_cnt       : completed-group counter, wraps
module ib_cnu6_cascade_ctrl
  import ib_cascade_pkg::*;
#(
  parameter int unsigned QUAN_SIZE      = 4,
  parameter int unsigned PIPELINE_DEPTH = 3,
  parameter int unsigned LUT_NUM        = 14,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  read_clk,
  input  logic                  rstn,
  ib_cnu6_cascade_ctrl_if.slave bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      done_cnt
);

  localparam int unsigned PipeLen = 4 * PIPELINE_DEPTH;
  localparam int unsigned AddrW   = lut_addr_w(QUAN_SIZE);
  localparam int unsigned SelW    = $clog2(LUT_NUM);

  cascade_state_t     state_q, state_d;
  logic [PipeLen-1:0] vpipe_q;
  logic [PipeLen:0]   vtap;
  logic [CNT_W-1:0]   done_cnt_q;
  logic               accept;
  logic               write_en;
  logic               walk_clear;
  logic               walk_last;

  // Ready is also forced low while reset is held.
  assign bus.v2c_ready = rstn && (state_q == StIdle) && !bus.load_req;
  assign accept        = bus.v2c_valid && bus.v2c_ready;

  // Tap 0 is the accept strobe itself, so a group shows on stage_valid[0] in its
  // accept cycle and leaves f3 exactly PipeLen cycles later.
  assign vtap = {vpipe_q, accept};

  for (genvar k = 0; k < 4; k++) begin : g_stage_tap
    assign bus.stage_valid[k] = vtap[k*PIPELINE_DEPTH];
  end

  assign bus.c2v_valid = vtap[PipeLen];

  assign write_en   = rstn && (state_q == StLoad) && bus.lut_wdata_valid;
  assign walk_clear = (state_q != StLoad);

  assign bus.lut_we    = write_en;
  assign bus.load_done = rstn && (state_q == StFinish);

  assign busy     = (state_q != StIdle) || (vpipe_q != '0);
  assign done_cnt = done_cnt_q;

  // load_req is only sampled in IDLE; once a reload starts it always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (bus.load_req) state_d = StDrain;
      StDrain:  if (vpipe_q == '0) state_d = StLoad;
      StLoad:   if (write_en && walk_last) state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge read_clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      vpipe_q    <= '0;
      done_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // No backpressure in the cascade: the pipe shifts every cycle in every state.
      vpipe_q <= {vpipe_q[PipeLen-2:0], accept};
      if (bus.c2v_valid) done_cnt_q <= done_cnt_q + CNT_W'(1);
    end
  end

  ib_lut_load_walker #(
    .ADDR_W  (AddrW),
    .LUT_NUM (LUT_NUM),
    .SEL_W   (SelW)
  ) u_walker (
    .read_clk (read_clk),
    .rstn     (rstn),
    .clear    (walk_clear),
    .advance  (write_en),
    .lut_sel  (bus.lut_sel),
    .lut_addr (bus.lut_addr),
    .last     (walk_last)
  );

endmodule

// File: tb/tb_ib_cnu6_cascade_ctrl.sv
// Directed self-checking bench for ib_cnu6_cascade_ctrl (CNT_W reduced to 4 so the
// completed-group counter wraps within a short run).
module tb_ib_cnu6_cascade_ctrl;

  localparam int unsigned QuanSize = 4;
  localparam int unsigned PipeDep  = 3;
  localparam int unsigned LutNum   = 14;
  localparam int unsigned CntW     = 4;
  localparam int unsigned Writes   = LutNum * 256;

  logic            read_clk;
  logic            rstn;
  logic            busy;
  logic [CntW-1:0] done_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  ib_cnu6_cascade_ctrl_if #(.QUAN_SIZE(QuanSize), .LUT_NUM(LutNum)) bus ();

  ib_cnu6_cascade_ctrl #(
    .QUAN_SIZE      (QuanSize),
    .PIPELINE_DEPTH (PipeDep),
    .LUT_NUM        (LutNum),
    .CNT_W          (CntW)
  ) dut (
    .read_clk (read_clk),
    .rstn     (rstn),
    .bus      (bus),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge read_clk);
    #1;
  endtask

  task automatic run_groups(input int n);
    for (int i = 0; i < n; i++) begin
      bus.v2c_valid = 1'b1;
      step();
    end
    bus.v2c_valid = 1'b0;
    repeat (14) step();
  endtask

  initial begin
    int first_c2v, last_c2v, n_c2v, n_ready;
    int c2v_seen, n_writes, walk_bad, cyc, last_wr_cyc, done_cyc;
    int exp_sel, exp_addr;
    bit phase, timed_out, hit;
    int n_done, n_busy;

    rstn                = 1'b0;
    bus.v2c_valid       = 1'b0;
    bus.load_req        = 1'b0;
    bus.lut_wdata_valid = 1'b0;

    // Reset state
    repeat (3) step();
    @(negedge read_clk);
    check_eq("rst_ready",  bus.v2c_ready, 0);
    check_eq("rst_stage",  bus.stage_valid, 0);
    check_eq("rst_c2v",    bus.c2v_valid, 0);
    check_eq("rst_we",     bus.lut_we, 0);
    check_eq("rst_sel",    bus.lut_sel, 0);
    check_eq("rst_addr",   bus.lut_addr, 0);
    check_eq("rst_done",   bus.load_done, 0);
    check_eq("rst_busy",   busy, 0);
    check_eq("rst_cnt",    done_cnt, 0);
    step();
    rstn = 1'b1;
    step();

    // Single group through all four stages
    bus.v2c_valid = 1'b1;
    @(negedge read_clk);
    check_eq("single_ready", bus.v2c_ready, 1);
    check_eq("single_stage0", bus.stage_valid, 4'h1);
    step();
    bus.v2c_valid = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge read_clk);
      check_eq($sformatf("single_stage_c%0d", i), bus.stage_valid,
               (i == 3) ? 2 : (i == 6) ? 4 : (i == 9) ? 8 : 0);
      check_eq($sformatf("single_c2v_c%0d", i), bus.c2v_valid, (i == 12) ? 1 : 0);
      step();
    end
    exp_cnt = (exp_cnt + 1) % 16;
    @(negedge read_clk);
    check_eq("single_cnt", done_cnt, exp_cnt);
    step();

    // Back-to-back stream of 20 groups
    first_c2v = -1; last_c2v = -1; n_c2v = 0; n_ready = 0;
    for (int i = 0; i < 40; i++) begin
      bus.v2c_valid = (i < 20);
      @(negedge read_clk);
      if (i < 20 && bus.v2c_ready) n_ready++;
      if (bus.c2v_valid) begin
        if (first_c2v < 0) first_c2v = i;
        last_c2v = i;
        n_c2v++;
      end
      step();
    end
    exp_cnt = (exp_cnt + 20) % 16;
    check_eq("stream_ready", n_ready, 20);
    check_eq("stream_first", first_c2v, 12);
    check_eq("stream_last",  last_c2v, 31);
    check_eq("stream_count", n_c2v, 20);
    @(negedge read_clk);
    check_eq("stream_cnt", done_cnt, exp_cnt);
    step();

    // Load request collides with a group while three groups are in flight
    c2v_seen = 0;
    for (int i = 0; i < 4; i++) begin
      bus.v2c_valid = 1'b1;
      bus.load_req  = (i == 3);
      @(negedge read_clk);
      if (i == 3) check_eq("collide_ready", bus.v2c_ready, 0);
      step();
    end
    bus.v2c_valid = 1'b0;

    // Full reload with a toggling word-valid; load_req dropped part way through
    n_writes = 0; walk_bad = 0; cyc = 0; last_wr_cyc = -1; done_cyc = -1;
    exp_sel = 0; exp_addr = 0; phase = 1'b1; timed_out = 1'b1;
    for (int i = 0; i < 9000; i++) begin
      bus.lut_wdata_valid = phase;
      phase = ~phase;
      @(negedge read_clk);
      if (bus.c2v_valid) c2v_seen++;
      if (n_writes > 0 && n_writes < Writes && bus.lut_we !== bus.lut_wdata_valid) walk_bad++;
      if (bus.lut_we) begin
        if (n_writes == 0) begin
          check_eq("load_after_drain", c2v_seen, 3);
          check_eq("load_first_sel", bus.lut_sel, 0);
          check_eq("load_first_addr", bus.lut_addr, 0);
        end
        if (n_writes == 200) begin
          check_eq("load_ready_low", bus.v2c_ready, 0);
          check_eq("load_busy", busy, 1);
        end
        if (n_writes == 256) begin
          check_eq("wrap_sel", bus.lut_sel, 1);
          check_eq("wrap_addr", bus.lut_addr, 0);
        end
        if (bus.lut_sel !== exp_sel[3:0] || bus.lut_addr !== exp_addr[7:0]) walk_bad++;
        if (exp_addr == 255) begin
          exp_addr = 0;
          exp_sel++;
        end else begin
          exp_addr++;
        end
        n_writes++;
        last_wr_cyc = cyc;
        if (n_writes == 100) bus.load_req = 1'b0;
      end
      if (bus.load_done) begin
        done_cyc  = cyc;
        timed_out = 1'b0;
        cyc++;
        step();
        break;
      end
      cyc++;
      step();
    end
    bus.lut_wdata_valid = 1'b0;
    check_eq("load_timeout", timed_out, 0);
    check_eq("load_writes", n_writes, Writes);
    check_eq("load_walk", walk_bad, 0);
    check_eq("load_c2v_total", c2v_seen, 3);
    check_eq("load_done_cycle", done_cyc, last_wr_cyc + 1);
    exp_cnt = (exp_cnt + 3) % 16;
    @(negedge read_clk);
    check_eq("post_load_done", bus.load_done, 0);
    check_eq("post_load_busy", busy, 0);
    check_eq("post_load_ready", bus.v2c_ready, 1);
    check_eq("post_load_cnt", done_cnt, exp_cnt);
    step();

    // Reset in the middle of a reload at lut_sel=5, lut_addr=77
    bus.load_req        = 1'b1;
    bus.lut_wdata_valid = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge read_clk);
      if (bus.lut_we && bus.lut_sel == 4'd5 && bus.lut_addr == 8'd77) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check_eq("midrst_reach", hit, 1);
    rstn = 1'b0;
    step();
    check_eq("midrst_sel",   bus.lut_sel, 0);
    check_eq("midrst_addr",  bus.lut_addr, 0);
    check_eq("midrst_we",    bus.lut_we, 0);
    check_eq("midrst_done",  bus.load_done, 0);
    check_eq("midrst_busy",  busy, 0);
    check_eq("midrst_ready", bus.v2c_ready, 0);
    check_eq("midrst_cnt",   done_cnt, 0);
    rstn                = 1'b1;
    bus.load_req        = 1'b0;
    bus.lut_wdata_valid = 1'b0;
    n_done = 0; n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge read_clk);
      if (bus.load_done) n_done++;
      if (busy) n_busy++;
      step();
    end
    check_eq("midrst_no_done", n_done, 0);
    check_eq("midrst_idle", n_busy, 0);
    exp_cnt = 0;

    // done_cnt wrap at CNT_W=4
    run_groups(15);
    exp_cnt = 15;
    @(negedge read_clk);
    check_eq("wrap_pre", done_cnt, exp_cnt);
    step();
    run_groups(1);
    exp_cnt = 0;
    @(negedge read_clk);
    check_eq("wrap_post", done_cnt, exp_cnt);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
